// File: rtl/bpu_update_buffer.sv
// FIFO of branch-predictor training updates from int writeback, drained into the
// BHT/BTB arrays only in cycles where the frontend leaves the predictor port idle.
`ifndef BHTBTB_INDEX_WIDTH
`define BHTBTB_INDEX_WIDTH 8
`endif

module bpu_update_buffer #(
  parameter int DEPTH          = 4,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            intwb_bjusb_bht_write_enable,
  input  logic [`BHTBTB_INDEX_WIDTH-1:0]  intwb_bjusb_bht_write_index,
  input  logic [1:0]                      intwb_bjusb_bht_write_counter_select,
  input  logic                            intwb_bjusb_bht_write_inc,
  input  logic                            intwb_bjusb_bht_write_dec,
  input  logic                            intwb_bjusb_bht_valid_in,
  input  logic                            intwb_bjusb_btb_ce,
  input  logic                            intwb_bjusb_btb_we,
  input  logic [128:0]                    intwb_bjusb_btb_wmask,
  input  logic [8:0]                      intwb_bjusb_btb_write_index,
  input  logic [128:0]                    intwb_bjusb_btb_din,
  input  logic                            frontend_bpu_read,
  output logic                            bpu_bht_write_enable,
  output logic [`BHTBTB_INDEX_WIDTH-1:0]  bpu_bht_write_index,
  output logic [1:0]                      bpu_bht_write_counter_select,
  output logic                            bpu_bht_write_inc,
  output logic                            bpu_bht_write_dec,
  output logic                            bpu_bht_valid_in,
  output logic                            bpu_btb_ce,
  output logic                            bpu_btb_we,
  output logic [128:0]                    bpu_btb_wmask,
  output logic [8:0]                      bpu_btb_write_index,
  output logic [128:0]                    bpu_btb_din,
  output logic [$clog2(DEPTH):0]          buf_count,
  output logic                            buf_full,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count
);

  localparam int IW = `BHTBTB_INDEX_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic          bht_we;
    logic [IW-1:0] bht_idx;
    logic [1:0]    bht_sel;
    logic          bht_inc;
    logic          bht_dec;
    logic          bht_valid;
    logic          btb_ce;
    logic          btb_we;
    logic [128:0]  btb_wmask;
    logic [8:0]    btb_idx;
    logic [128:0]  btb_din;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              entry_in;
  entry_t              head;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                enq, pop, full, empty, accept;

  assign enq    = intwb_bjusb_bht_write_enable | intwb_bjusb_btb_ce;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign pop    = !empty && !frontend_bpu_read;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign accept = enq && (!full || pop);

  // Absent halves are zeroed so a drained entry never carries stale fields.
  always_comb begin
    entry_in           = '0;
    entry_in.bht_we    = intwb_bjusb_bht_write_enable;
    entry_in.btb_ce    = intwb_bjusb_btb_ce;
    if (intwb_bjusb_bht_write_enable) begin
      entry_in.bht_idx   = intwb_bjusb_bht_write_index;
      entry_in.bht_sel   = intwb_bjusb_bht_write_counter_select;
      entry_in.bht_inc   = intwb_bjusb_bht_write_inc;
      entry_in.bht_dec   = intwb_bjusb_bht_write_dec;
      entry_in.bht_valid = intwb_bjusb_bht_valid_in;
    end
    if (intwb_bjusb_btb_ce) begin
      entry_in.btb_we    = intwb_bjusb_btb_we;
      entry_in.btb_wmask = intwb_bjusb_btb_wmask;
      entry_in.btb_idx   = intwb_bjusb_btb_write_index;
      entry_in.btb_din   = intwb_bjusb_btb_din;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
    if (accept && !pop)      count_d = count_q + CW'(1);
    else if (!accept && pop) count_d = count_q - CW'(1);
    if (enq && !accept && (drop_q != '1)) drop_d = drop_q + DROP_CNT_WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem_q[wr_ptr_q] <= entry_in;
  end

  assign head = pop ? mem_q[rd_ptr_q] : '0;

  assign bpu_bht_write_enable         = head.bht_we;
  assign bpu_bht_write_index          = head.bht_idx;
  assign bpu_bht_write_counter_select = head.bht_sel;
  assign bpu_bht_write_inc            = head.bht_inc;
  assign bpu_bht_write_dec            = head.bht_dec;
  assign bpu_bht_valid_in             = head.bht_valid;
  assign bpu_btb_ce                   = head.btb_ce;
  assign bpu_btb_we                   = head.btb_we;
  assign bpu_btb_wmask                = head.btb_wmask;
  assign bpu_btb_write_index          = head.btb_idx;
  assign bpu_btb_din                  = head.btb_din;

  assign buf_count  = count_q;
  assign buf_full   = full;
  assign drop_count = drop_q;

endmodule

// File: doc/bpu_update_buffer.md
# bpu_update_buffer

Buffers branch-predictor training updates emitted by the integer writeback pipeline register. Each buffered update can carry a BHT counter update, a BTB entry write, or both. The block drains updates in order into the BHT/BTB arrays, using only cycles in which the frontend is not reading those arrays. It sits between the int writeback stage and the frontend predictor SRAMs, and it decouples backend branch resolution from frontend port usage.

## Interface
Parameters:
- DEPTH, 4, number of buffered update entries; power of two, 2..16.
- DROP_CNT_WIDTH, 8, width of the saturating dropped-update counter.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- intwb_bjusb_bht_write_enable  in  1  BHT update present.
- intwb_bjusb_bht_write_index  in  `BHTBTB_INDEX_WIDTH  BHT set index.
- intwb_bjusb_bht_write_counter_select  in  2  counter within set.
- intwb_bjusb_bht_write_inc / _dec  in  1 each  counter direction.
- intwb_bjusb_bht_valid_in  in  1  valid bit to write.
- intwb_bjusb_btb_ce  in  1  BTB update present.
- intwb_bjusb_btb_we  in  1  BTB write enable.
- intwb_bjusb_btb_wmask  in  129  BTB bit mask.
- intwb_bjusb_btb_write_index  in  9  BTB index.
- intwb_bjusb_btb_din  in  129  BTB data.
- frontend_bpu_read  in  1  frontend is using the BHT/BTB port this cycle.
- bpu_bht_write_enable, bpu_bht_write_index, bpu_bht_write_counter_select, bpu_bht_write_inc, bpu_bht_write_dec, bpu_bht_valid_in  out  same widths as inputs  drained BHT update.
- bpu_btb_ce, bpu_btb_we, bpu_btb_wmask, bpu_btb_write_index, bpu_btb_din  out  same widths as inputs  drained BTB update.
- buf_count  out  $clog2(DEPTH)+1  occupied entries.
- buf_full  out  1  buf_count == DEPTH.
- drop_count  out  DROP_CNT_WIDTH  saturating count of discarded updates.

## Operation
- enq = intwb_bjusb_bht_write_enable | intwb_bjusb_btb_ce.
- On enq, all BHT and BTB input fields are captured into one entry at wr_ptr.
- Field qualification:
  - An entry stores bht_write_enable and btb_ce exactly as presented.
  - When bht_write_enable is 0, its BHT fields are stored as 0.
  - When btb_ce is 0, its BTB fields are stored as 0.
- pop = !empty & !frontend_bpu_read.
- Head-entry outputs:
  - The head entry drives all bpu_* outputs combinationally.
  - bpu_bht_write_enable = pop & head.bht_write_enable.
  - bpu_btb_ce = pop & head.btb_ce.
  - bpu_btb_we = pop & head.btb_we.
  - All other bpu_* fields are 0 when pop = 0.
  - One entry drains per popped cycle; BHT and BTB halves of an entry always drain together.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. buf_count tracks occupancy: +1 on accepted enq, -1 on pop, unchanged when both occur.
- Full behaviour:
  - If enq is asserted while full and pop = 0, the update is discarded.
  - In that case drop_count increments and saturates at all-ones.
  - If full and pop = 1 in the same cycle, enq is accepted; buf_count stays DEPTH.
- Empty behaviour: no pop occurs and all bpu_* enables are 0. An enq into an empty buffer does not bypass; it becomes the head on the next cycle.
- Order is strict FIFO. No reordering or merging of updates to the same index.

## Timing
- Reset (asynchronous, reset_n = 0):
  - wr_ptr = 0, rd_ptr = 0, buf_count = 0, drop_count = 0.
  - Entry storage is don't-care.
  - Every bpu_* output = 0, buf_full = 0.
- Reset asserted mid-operation discards all buffered entries immediately. No write is issued while reset_n = 0.
- Latency: an update captured at edge N can drive bpu_* in cycle N+1 at the earliest, if frontend_bpu_read = 0 in that cycle.
- frontend_bpu_read stalls the drain for exactly the cycles in which it is 1. There is no starvation guard; the frontend owns port priority.
- buf_full and buf_count are registered-state derived, with no combinational path from enq. bpu_* depend combinationally on frontend_bpu_read only.
- Sustained throughput is one update per cycle when frontend_bpu_read = 0.

## Test plan
- Single update, idle frontend:
  - Stimulus: enq BHT index 5, counter_select 2, inc = 1 at cycle 0.
  - Required: cycle 1 shows bpu_bht_write_enable = 1 with index 5, select 2, inc 1, and bpu_btb_ce = 0. Cycle 2 shows buf_count = 0.
- Stall then drain:
  - Stimulus: frontend_bpu_read = 1 for cycles 0–5; enq 3 BTB updates with indices 0x10, 0x11, 0x12 at cycles 0–2; release at cycle 6.
  - Required: no bpu_btb_ce during cycles 0–5. Cycles 6, 7, 8 emit 0x10, 0x11, 0x12 with their din and wmask intact.
- Overflow (DEPTH = 4):
  - Stimulus: frontend_bpu_read = 1; enq 6 updates.
  - Required: buf_full = 1 after the 4th update, drop_count = 2. On release, the first 4 updates drain in order.
- Full with simultaneous enq and pop:
  - Stimulus: buffer full, frontend_bpu_read = 0, enq in the same cycle.
  - Required: the head drains, the new entry is accepted, buf_count stays 4, drop_count is unchanged.
- Combined entry and wrap-around:
  - Stimulus: stream 10 updates with both BHT and BTB present, alternating frontend_bpu_read.
  - Required: each output cycle shows both enables together. Order is preserved across pointer wrap; drop_count = 0.
- Reset mid-operation:
  - Stimulus: 3 buffered entries, then reset_n pulsed low asynchronously between edges.
  - Required: buf_count and all bpu_* outputs go to 0 immediately. No stale entry drains after reset_n returns high.
